// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for an N-digit 7-segment display.
// It has a prescaled digit scan, guard cycles, leading-zero blanking and a frame-coherent shadow copy.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_done
);

  localparam int CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_value_q, shadow_value_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;
  logic                    slot_end, frame_end;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   upper_zero;  // bit k: nibbles k..N-1 are all zero

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt_q == CntLast);
  assign frame_end = slot_end && (idx_q == IdxLast);

  always_comb begin
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    frame_done_d   = 1'b0;
    if (!enable) begin
      cnt_d          = '0;
      idx_d          = '0;
      shadow_value_d = value;
      shadow_dp_d    = dp_in;
    end else if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      if (frame_end) begin
        shadow_value_d = value;
        shadow_dp_d    = dp_in;
        frame_done_d   = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    upper_zero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      upper_zero[k] = ((shadow_value_q >> (4 * k)) == '0);
    end
    nib   = shadow_value_q[{idx_q, 2'b00} +: 4];
    dig_d = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (enable) begin
      if (int'(cnt_q) >= GUARD_CYCLES) dig_d[idx_q] = 1'b1;
      // A blanked digit stays selected but lights nothing.
      if (!(blank_lz && (idx_q != '0) && upper_zero[idx_q])) begin
        seg_d = hex7(nib);
        dp_d  = shadow_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      dig_q          <= '0;
      seg_q          <= '0;
      dp_q           <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      dig_q          <= dig_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp         = (SEG_ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign dig        = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: the driver queues cycle-tagged expectations
// and a monitor compares both polarity variants after each clock edge.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111, S4 = 7'b1100110, S8 = 7'b1111111;
  localparam logic [6:0] SA = 7'b1110111, SB = 7'b1111100, SC = 7'b0111001;
  localparam logic [6:0] SD = 7'b1011110, SF = 7'b1110001, SX = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg, seg_n;
  logic        dp, dp_n, fd, fd_n;
  logic [3:0]  dig, dig_n;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;
  exp_t sb[$];

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1),
                     .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .dig(dig), .frame_done(fd));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1),
                     .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut_inv (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_n), .dp(dp_n), .dig(dig_n), .frame_done(fd_n));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got{dig,seg,dp,fd}=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  // Monitor: pops the expectation tagged for the current cycle.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missed cyc=%0d expectation for cyc=%0d never checked", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("active_high", {dig, seg, dp, fd}, {e.dig, e.seg, e.dp, e.fd});
      check("active_low", {dig_n, seg_n, dp_n, fd_n}, {~e.dig, ~e.seg, ~e.dp, e.fd});
    end
  end

  task automatic push_dark(input int at);
    exp_t e;
    e.cyc = at; e.dig = '0; e.seg = '0; e.dp = 1'b0; e.fd = 1'b0;
    sb.push_back(e);
  endtask

  // Queue the first n cycles of a frame starting at cycle base (1 guard cycle per slot).
  task automatic push_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] edp, input int n);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int k;
      k = i / 4;
      e.cyc = base + i;
      e.dig = (i % 4 == 0) ? 4'b0000 : (4'b0001 << k);
      e.seg = s[k];
      e.dp  = edp[k];
      e.fd  = (i == 15);
      sb.push_back(e);
    end
  endtask

  // One dark cycle loads the shadow, then a full frame is scanned and checked.
  task automatic new_frame(input logic [15:0] v, input logic [3:0] d, input logic lz,
                           input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [3:0] edp);
    enable = 1'b0; value = v; dp_in = d; blank_lz = lz;
    push_dark(cyc + 1);
    @(negedge clk);
    enable = 1'b1;
    push_frame(cyc + 1, s0, s1, s2, s3, edp, 16);
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (2) @(negedge clk);
    check("reset_hi", {dig, seg, dp, fd}, 13'b0);
    check("reset_lo", {dig_n, seg_n, dp_n, fd_n}, {4'hF, 7'h7F, 1'b1, 1'b0});
    rst_n = 1'b1;

    new_frame(16'h1A3F, 4'b0000, 1'b0, SF, S3, SA, S1, 4'b0000);
    new_frame(16'h0040, 4'b1111, 1'b1, S0, S4, SX, SX, 4'b0011);
    new_frame(16'h0000, 4'b0000, 1'b1, S0, SX, SX, SX, 4'b0000);
    new_frame(16'h0800, 4'b0101, 1'b1, S0, S0, S8, SX, 4'b0101);
    new_frame(16'h0008, 4'b0001, 1'b0, S8, S0, S0, S0, 4'b0001);

    // Mid-frame input change must not tear the current frame.
    enable = 1'b0; value = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
    push_dark(cyc + 1);
    @(negedge clk);
    enable = 1'b1;
    base = cyc + 1;
    push_frame(base, S4, S3, S2, S1, 4'b0000, 16);
    push_frame(base + 16, SD, SC, SB, SA, 4'b0000, 16);
    repeat (5) @(negedge clk);
    value = 16'hABCD;
    repeat (27) @(negedge clk);

    // Drop enable in the guard cycle of slot 2, then restart from slot 0.
    push_frame(cyc + 1, SD, SC, SB, SA, 4'b0000, 9);
    repeat (9) @(negedge clk);
    new_frame(16'hABCD, 4'b0000, 1'b0, SD, SC, SB, SA, 4'b0000);

    // Asynchronous reset mid-slot; the shadow returns to zero and the scan restarts.
    push_frame(cyc + 1, SD, SC, SB, SA, 4'b0000, 6);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midslot_reset_hi", {dig, seg, dp, fd}, 13'b0);
    check("midslot_reset_lo", {dig_n, seg_n, dp_n, fd_n}, {4'hF, 7'h7F, 1'b1, 1'b0});
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(cyc + 1, S0, S0, S0, S0, 4'b0000, 16);
    repeat (16) @(negedge clk);

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
